// File: rtl/seq_stream_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_stream_ctrl_if
//  Purpose  : Bundles the request/result side and the detector side of the
//             sequence-detector stream controller into one port.
//  Signals  : start, abort, len, data      - run request from the host
//             det_y / det_x, det_r         - serial detector connection
//             busy, done, aborted,
//             hit_cnt, hit_seen, first_hit - run status and results
//  Modports : slave  - the controller
//             master - the host/detector environment driving the controller
//  Revision : 1.0 - initial release
// ============================================================================
interface seq_stream_ctrl_if #(
    parameter int DATA_W = 27,
    parameter int LEN_W  = 5,
    parameter int CNT_W  = 5
);
    logic              start;
    logic              abort;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
    logic              det_y;
    logic              det_x;
    logic              det_r;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [CNT_W-1:0]  hit_cnt;
    logic              hit_seen;
    logic [LEN_W-1:0]  first_hit;

    modport slave (
        input  start, abort, len, data, det_y,
        output det_x, det_r, busy, done, aborted, hit_cnt, hit_seen, first_hit
    );

    modport master (
        output start, abort, len, data, det_y,
        input  det_x, det_r, busy, done, aborted, hit_cnt, hit_seen, first_hit
    );
endinterface
`default_nettype wire

// File: rtl/seq_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seq_stream_ctrl
//  Purpose  : Streams a parallel word LSB-first into a serial sequence
//             detector, one bit per clock, after clearing the detector.
//             Counts detector hits (saturating), records the bit index of
//             the first hit, and signals completion with a one-cycle done
//             pulse. A run can be aborted mid-stream.
//  Ports    : clk - system clock, rising edge
//             r   - synchronous active-high reset
//             bus - seq_stream_ctrl_if.slave (request, detector, results)
//  Revision : 1.0 - initial release
// ============================================================================
module seq_stream_ctrl #(
    parameter int DATA_W = 27,
    parameter int LEN_W  = 5,
    parameter int CNT_W  = 5
) (
    input  wire logic        clk,
    input  wire logic        r,
    seq_stream_ctrl_if.slave bus
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_CLR   = 3'd1;
    localparam logic [2:0] c_ST_SHIFT = 3'd2;
    localparam logic [2:0] c_ST_DRAIN = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    localparam logic [LEN_W-1:0] c_LEN_MAX = LEN_W'(DATA_W);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [2:0]        r_state;
    logic [DATA_W-1:0] r_sr;       // remaining bits; bit 0 is the one on det_x
    logic [LEN_W-1:0]  r_last;     // index of the final bit, L-1
    logic [LEN_W-1:0]  r_idx;      // index of the bit currently on det_x

    logic              r_det_x;
    logic              r_det_r;
    logic              r_busy;
    logic              r_done;
    logic              r_aborted;
    logic [CNT_W-1:0]  r_hit_cnt;
    logic              r_hit_seen;
    logic [LEN_W-1:0]  r_first_hit;

    logic [LEN_W-1:0]  w_len;
    logic              w_sample;
    logic [LEN_W-1:0]  w_bit;
    logic              w_hit;

    // Zero or out-of-range lengths stream the full word.
    always_comb begin
        w_len = bus.len;
        if (bus.len == '0 || bus.len > c_LEN_MAX) begin
            w_len = c_LEN_MAX;
        end
    end

    // The detector output lags det_x by one cycle, so the y seen while bit
    // idx is presented belongs to bit idx-1; DRAIN collects the final bit.
    always_comb begin
        w_sample = 1'b0;
        w_bit    = r_idx - LEN_W'(1);
        if (r_state == c_ST_SHIFT && r_idx != '0) begin
            w_sample = 1'b1;
        end
        if (r_state == c_ST_DRAIN) begin
            w_sample = 1'b1;
            w_bit    = r_last;
        end
        w_hit = w_sample & bus.det_y;
    end

    always_ff @(posedge clk) begin
        if (r) begin
            r_state     <= c_ST_IDLE;
            r_sr        <= '0;
            r_last      <= '0;
            r_idx       <= '0;
            r_det_x     <= 1'b1;
            r_det_r     <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_hit_cnt   <= '0;
            r_hit_seen  <= 1'b0;
            r_first_hit <= '0;
        end else begin
            r_done <= 1'b0;

            if (w_hit) begin
                if (r_hit_cnt != c_CNT_MAX) begin
                    r_hit_cnt <= r_hit_cnt + CNT_W'(1);
                end
                if (!r_hit_seen) begin
                    r_hit_seen  <= 1'b1;
                    r_first_hit <= w_bit;
                end
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        r_sr    <= bus.data;
                        r_last  <= w_len - LEN_W'(1);
                        r_busy  <= 1'b1;
                        r_state <= c_ST_CLR;
                    end
                end

                c_ST_CLR: begin
                    r_hit_cnt   <= '0;
                    r_hit_seen  <= 1'b0;
                    r_first_hit <= '0;
                    r_aborted   <= bus.abort;
                    r_idx       <= '0;
                    if (bus.abort) begin
                        r_state <= c_ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= c_ST_SHIFT;
                        r_det_r <= 1'b0;
                        r_det_x <= r_sr[0];
                    end
                end

                c_ST_SHIFT: begin
                    if (bus.abort) begin
                        r_aborted <= 1'b1;
                        r_state   <= c_ST_DONE;
                        r_done    <= 1'b1;
                        r_det_r   <= 1'b1;
                        r_det_x   <= 1'b1;
                    end else if (r_idx == r_last) begin
                        // Idle-high x while the last bit's y is collected.
                        r_state <= c_ST_DRAIN;
                        r_det_x <= 1'b1;
                    end else begin
                        r_idx   <= r_idx + LEN_W'(1);
                        r_det_x <= r_sr[1];
                        r_sr    <= r_sr >> 1;
                    end
                end

                c_ST_DRAIN: begin
                    if (bus.abort) begin
                        r_aborted <= 1'b1;
                    end
                    r_state <= c_ST_DONE;
                    r_done  <= 1'b1;
                    r_det_r <= 1'b1;
                    r_det_x <= 1'b1;
                end

                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                    r_det_r <= 1'b1;
                    r_det_x <= 1'b1;
                end
            endcase
        end
    end

    assign bus.det_x     = r_det_x;
    assign bus.det_r     = r_det_r;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.aborted   = r_aborted;
    assign bus.hit_cnt   = r_hit_cnt;
    assign bus.hit_seen  = r_hit_seen;
    assign bus.first_hit = r_first_hit;

endmodule
`default_nettype wire

// File: doc/seq_stream_ctrl.md
Name: seq_stream_ctrl

Overview:
- Sequencer for the serial sequence-detector datapath (clk, r, x in; y out).
- Accepts a parallel word plus a bit count, then clears the detector.
- Shifts the word into the detector LSB-first, one bit per clock, and collects the detector's y pulses.
- Reports the hit count and the first-hit bit index with a done pulse; supports mid-stream abort.

Parameters:
- DATA_W, 27, maximum stream length in bits (width of data).
- LEN_W, 5, width of len and first_hit; must satisfy 2^LEN_W > DATA_W.
- CNT_W, 5, width of hit_cnt (saturating).

Ports:
- clk  input  1  system clock, rising edge.
- r  input  1  synchronous, active-high reset.
- start  input  1  request to stream; sampled only in IDLE.
- abort  input  1  terminate the current stream.
- len  input  LEN_W  number of bits to send; 0 or >DATA_W is treated as DATA_W.
- data  input  DATA_W  word to stream; bit 0 is sent first.
- det_y  input  1  detector output y.
- det_x  output  1  detector serial input x.
- det_r  output  1  detector reset.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- aborted  output  1  last run ended by abort.
- hit_cnt  output  CNT_W  number of det_y=1 samples in the last run, saturating at 2^CNT_W-1.
- hit_seen  output  1  at least one hit in the last run.
- first_hit  output  LEN_W  bit index whose sample produced the first hit.

Behaviour:
- All outputs are registered.
- Reset (r=1 at an edge): state=IDLE, det_x=1, det_r=1, busy=0, done=0, aborted=0, hit_cnt=0, hit_seen=0, first_hit=0.
- r overrides every other input, including during a stream.
- States are IDLE, CLR, SHIFT, DRAIN and DONE.
  - IDLE: det_r=1, det_x=1. If start=1, latch data and the clamped len (L) into a shift register and length counter, then go to CLR. start is ignored in all other states.
  - CLR (1 cycle): det_r=1, det_x=1. Clear hit_cnt, hit_seen, first_hit and aborted. Bit index idx=0. Go to SHIFT.
  - SHIFT (L cycles): det_r=0, det_x=data[idx]; idx increments each cycle.
    - In every SHIFT cycle with idx>=1, sample det_y; the sample is attributed to bit idx-1.
    - After the cycle with idx=L-1, go to DRAIN.
  - DRAIN (1 cycle): det_r=0, det_x=1. Sample det_y, attributed to bit L-1. Go to DONE.
  - DONE (1 cycle): done=1, det_r=1, det_x=1. Go to IDLE.
- Hit sample (det_y=1):
  - hit_cnt increments unless it is at its maximum.
  - If hit_seen=0: set hit_seen=1 and first_hit=attributed index.
- Latency: start accepted at edge k gives CLR in cycle k+1, SHIFT in cycles k+2..k+1+L, DRAIN in k+2+L, DONE in k+3+L, and IDLE from k+4+L.
- Results (hit_cnt, hit_seen, first_hit, aborted) hold from DONE until the next CLR.
- abort=1 in CLR, SHIFT or DRAIN:
  - The det_y sample of that same cycle is still taken.
  - Next state is DONE with aborted=1.
  - Remaining bits are discarded.
- abort in IDLE or DONE is ignored.
- abort and start together in IDLE: start wins and abort is ignored.
- L=1: SHIFT lasts one cycle with no sample; DRAIN provides the only sample.
- det_y is ignored in IDLE, CLR and DONE.

Test Plan:
Bench detector model: Moore "101" detector, y high in the cycle after the edge that completes the pattern; overlapping matches allowed.
- Nominal run: data=8'b00101101, len=8, start pulse → det_x sequence 1,0,1,1,0,1,0,0. done exactly 11 cycles after the start edge. hit_cnt=2, hit_seen=1, first_hit=2, aborted=0.
- Last-bit hit: data=3'b101, len=3 → the hit is caught only in DRAIN. hit_cnt=1, first_hit=2, done 6 cycles after start.
- Abort: data=8'b00101101, len=8, abort asserted in the SHIFT cycle with idx=4 → DONE in the next cycle with aborted=1, hit_cnt=1, first_hit=2. det_r=1 in that DONE cycle.
- Clamp/saturation: CNT_W=2, len=0 (streams DATA_W=27 bits), data=alternating 1,0,1,0,... from bit 0 → 13 matches, hit_cnt saturates at 3, first_hit=2, done 30 cycles after start.
- Protocol: start pulse during SHIFT is ignored (no restart, same results). Asserting r during SHIFT returns to IDLE next cycle with all outputs at reset values and det_r=1.
- Back-to-back: start held high continuously → runs repeat with 1 IDLE cycle between DONE and the next CLR. Results are cleared in each CLR.
